qea_core: RTL and testbench
===========================

Name: qea_core

Overview:
- Quantum-emulation accelerator: holds an n-qubit state vector (n = i_qbit_num, 2 to 2^MAX_QBIT_WIDTH-1, limited by memory depth) in PE_NUM lane-parallel state RAMs.
- Holds a gate program in a context RAM.
- On i_start, executes the program by applying 2x2 complex unitaries (optionally controlled) to the state.
- Host loads and reads state and program through simple RAM ports.
- Amplitudes are Q2.30 complex; 0x40000000 = 1.0.

Parameters:
- PE_NUM_WIDTH, 2, log2 of PE_NUM
- PE_NUM, 4, amplitudes per state word (lanes)
- DATA_WIDTH, 32, real/imag component width
- MAX_QBIT_WIDTH, 6, width of qubit-index fields
- ALU_DATA_WIDTH, DATA_WIDTH, multiplier operand width
- STATE_DATA_WIDTH, 2*DATA_WIDTH, one complex amplitude, {re,im}, re in upper half
- STATE_ADDR_WIDTH, 16, state RAM address width
- GATE_DATA_WIDTH, 2*DATA_WIDTH, one matrix element
- GATE_ADDR_WIDTH, 6, reserved gate-buffer address width
- GATE_CONTEXT_DATA_WIDTH, 2*DATA_WIDTH, context word width
- GATE_CONTEXT_ADDR_WIDTH, 16, context RAM address width
- NUM_FRAC_BIT, 30, fractional bits of fixed point

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- i_start  in  1  one-cycle start pulse
- i_qbit_num  in  MAX_QBIT_WIDTH  qubit count n
- i_ctx_en  in  1  context port enable
- i_ctx_wea  in  1  context write enable
- i_ctx_addr  in  GATE_CONTEXT_ADDR_WIDTH  context address
- i_ctx_data  in  GATE_CONTEXT_DATA_WIDTH  context write data
- i_state_ena  in  PE_NUM  per-lane state port enable
- i_state_wea  in  PE_NUM  per-lane state write enable
- i_state_addra  in  STATE_ADDR_WIDTH  state word address
- i_state_dina  in  PE_NUM*STATE_DATA_WIDTH  state write data
- o_complete  out  1  program finished (level)
- o_state_dout  out  STATE_DATA_WIDTH*PE_NUM  state read data

Behaviour:
- Single clock clk; reset rst_n asynchronous, active-low. On reset: FSM IDLE, o_complete=0, o_state_dout=0. RAM contents are not cleared.
- Amplitude index k = addr*PE_NUM + lane. Lane 0 occupies the most significant STATE_DATA_WIDTH bits of a state word. Valid addresses are 0..2^(n-2)-1.
- Host state port is active only in IDLE and is ignored while busy. It is read-first:
  - lane with ena=1: o_state_dout lane = old contents one cycle later;
  - if wea also =1: the lane is then overwritten with dina;
  - lanes with ena=0 hold their previous dout.
- Context port is active in IDLE only; write when en&wea.
- Context program format, in words from address 0:
  - Header word: [63:60] opcode (0=END, 1=GATE); [MAX_QBIT_WIDTH-1:0] target t; [8+MAX_QBIT_WIDTH-1:8] control c; bit 16 = control valid.
  - A GATE header is followed by 4 words: u00, u01, u10, u11, each {re,im} Q2.30.
  - An undefined opcode is treated as END.
- FSM: IDLE -> FETCH (header, 1-cycle RAM latency) -> LOADU (4 words) -> APPLY -> FETCH ... ; END -> DONE -> IDLE.
  - i_start is sampled in IDLE only and clears o_complete the next cycle.
  - In DONE, o_complete is set to 1 and held until the next accepted i_start.
- APPLY, for every index i < 2^n with bit t = 0, j = i | (1<<t):
  - If control is valid and bit c of i is 0, the pair is skipped.
  - Otherwise a' = u00*a + u01*b and b' = u10*a + u11*b, written back to both locations.
  - Pairs are processed sequentially (t < PE_NUM_WIDTH: same word; otherwise two words), at most 8 cycles per pair.
- Arithmetic:
  - Complex multiply re = ar*br - ai*bi, im = ar*bi + ai*br.
  - Each product is a 2*DATA_WIDTH signed value, arithmetic-shifted right by NUM_FRAC_BIT and truncated to DATA_WIDTH.
  - Sums wrap modulo 2^DATA_WIDTH; no saturation.
- Boundary cases:
  - t >= n or c >= n: the gate is skipped.
  - Context address wraps at 2^GATE_CONTEXT_ADDR_WIDTH.
  - i_start while busy is ignored.
  - Reset mid-run aborts to IDLE; RAM contents are undefined.

Decomposition:
- Package qea_pkg: opcode constants (OP_END, OP_GATE), header field offsets, FSM state enum, Q2.30 ONE constant.
- One sub-module, qea_butterfly: takes a, b and u00..u11; produces a', b'. Combinational or 1-stage registered.

Test Plan:
- Reset mid-operation -> o_complete=0, o_state_dout=0, FSM IDLE; a new i_start runs normally.
- Write addr0 = {4x distinct values}, then read with ena=wea=1111 -> old values returned on dout, then overwritten.
- n=8, |0> (addr0 lane0 = 0x40000000_00000000), program {END} -> o_complete=1 within 4 cycles of i_start; state unchanged.
- X on t=0 (u01=u10=0x40000000_00000000) -> amplitude 1.0 moves to index 1 (addr0 lane1).
- H on t=7 (all u=0x2D413CCC, u11 negated) -> indices 0 and 128 ≈ 0x2D413CCC, all others 0.
- CNOT c=0, t=1 on state index1 = 1.0 -> index3 = 1.0; with index0 = 1.0 instead, the state is unchanged.

Source files
------------

// File: rtl/qea_pkg.sv
`default_nettype none
// qea_pkg: opcodes, context header field offsets, FSM states and Q2.30 constants.
// Rev 1.0
package qea_pkg;

  localparam logic [3:0]  OP_END     = 4'd0;
  localparam logic [3:0]  OP_GATE    = 4'd1;

  localparam int          HDR_OP_LSB = 60;
  localparam int          HDR_T_LSB  = 0;
  localparam int          HDR_C_LSB  = 8;
  localparam int          HDR_CV_BIT = 16;

  localparam logic [31:0] Q_ONE      = 32'h4000_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOADU,
    S_APPLY,
    S_DONE
  } qea_state_e;

endpackage
`default_nettype wire

// File: rtl/qea_butterfly.sv
`default_nettype none
// qea_butterfly: combinational 2x2 complex unitary on one amplitude pair, Q2.30 wrap arithmetic.
// Rev 1.0
module qea_butterfly #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_FRAC_BIT = 30
) (
  input  logic [2*DATA_WIDTH-1:0] a_i,
  input  logic [2*DATA_WIDTH-1:0] b_i,
  input  logic [2*DATA_WIDTH-1:0] u00_i,
  input  logic [2*DATA_WIDTH-1:0] u01_i,
  input  logic [2*DATA_WIDTH-1:0] u10_i,
  input  logic [2*DATA_WIDTH-1:0] u11_i,
  output logic [2*DATA_WIDTH-1:0] a_o,
  output logic [2*DATA_WIDTH-1:0] b_o
);

  localparam int W = DATA_WIDTH;

  // Each product is rounded toward -inf by the shift before the terms are summed.
  function automatic logic [W-1:0] qmul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [2*W-1:0] p;
    p = $signed({{W{x[W-1]}}, x}) * $signed({{W{y[W-1]}}, y});
    return p[NUM_FRAC_BIT +: W];
  endfunction

  function automatic logic [2*W-1:0] cmul(input logic [2*W-1:0] x, input logic [2*W-1:0] y);
    logic [W-1:0] re;
    logic [W-1:0] im;
    re = qmul(x[2*W-1:W], y[2*W-1:W]) - qmul(x[W-1:0], y[W-1:0]);
    im = qmul(x[2*W-1:W], y[W-1:0]) + qmul(x[W-1:0], y[2*W-1:W]);
    return {re, im};
  endfunction

  function automatic logic [2*W-1:0] cadd(input logic [2*W-1:0] x, input logic [2*W-1:0] y);
    return {x[2*W-1:W] + y[2*W-1:W], x[W-1:0] + y[W-1:0]};
  endfunction

  assign a_o = cadd(cmul(u00_i, a_i), cmul(u01_i, b_i));
  assign b_o = cadd(cmul(u10_i, a_i), cmul(u11_i, b_i));

endmodule
`default_nettype wire

// File: rtl/qea_core.sv
`default_nettype none
// qea_core: state-vector quantum emulator; runs a gate program from context RAM on lane-parallel state RAMs.
// Rev 1.0
module qea_core
  import qea_pkg::*;
#(
  parameter int PE_NUM_WIDTH            = 2,
  parameter int PE_NUM                  = 4,
  parameter int DATA_WIDTH              = 32,
  parameter int MAX_QBIT_WIDTH          = 6,
  parameter int ALU_DATA_WIDTH          = DATA_WIDTH,
  parameter int STATE_DATA_WIDTH        = 2*DATA_WIDTH,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_DATA_WIDTH         = 2*DATA_WIDTH,
  parameter int GATE_ADDR_WIDTH         = 6,
  parameter int GATE_CONTEXT_DATA_WIDTH = 2*DATA_WIDTH,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int NUM_FRAC_BIT            = 30
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_start,
  input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
  input  logic                                 i_ctx_en,
  input  logic                                 i_ctx_wea,
  input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_ctx_addr,
  input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_data,
  input  logic [PE_NUM-1:0]                    i_state_ena,
  input  logic [PE_NUM-1:0]                    i_state_wea,
  input  logic [STATE_ADDR_WIDTH-1:0]          i_state_addra,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dina,
  output logic                                 o_complete,
  output logic [STATE_DATA_WIDTH*PE_NUM-1:0]   o_state_dout
);

  localparam int SDW   = STATE_DATA_WIDTH;
  localparam int IDX_W = STATE_ADDR_WIDTH + PE_NUM_WIDTH;

  qea_state_e                          state_q, state_d;
  logic [2:0]                          step_q, step_d;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [GATE_ADDR_WIDTH-1:0]          ld_q, ld_d;
  logic [MAX_QBIT_WIDTH-1:0]           n_q, n_d, t_q, t_d, c_q, c_d;
  logic                                cv_q, cv_d, complete_q, complete_d;
  logic [GATE_DATA_WIDTH-1:0]          u_q [4];
  logic [GATE_DATA_WIDTH-1:0]          u_d [4];
  logic [IDX_W-1:0]                    p_q, p_d;
  logic [SDW-1:0]                      a_q, a_d, b_q, b_d;

  logic [GATE_CONTEXT_DATA_WIDTH-1:0]  ctx_mem [2**GATE_CONTEXT_ADDR_WIDTH];
  logic [GATE_CONTEXT_DATA_WIDTH-1:0]  ctx_rd_q;

  logic                                w_host, w_ctl_ok, w_gate_ok, w_use_j;
  logic [3:0]                          w_op;
  logic [IDX_W-1:0]                    w_mask, w_i, w_j, w_p_last, w_eng_idx;
  logic [STATE_ADDR_WIDTH-1:0]         w_eng_addr;
  logic [PE_NUM_WIDTH-1:0]             w_eng_lane;
  logic [SDW-1:0]                      w_eng_rd [PE_NUM];
  logic [SDW-1:0]                      w_a_new, w_b_new, w_eng_din;

  assign w_host    = (state_q == S_IDLE);
  assign w_op      = ctx_rd_q[HDR_OP_LSB +: 4];

  // Pair counter p enumerates indices with bit t cleared: splice a zero into p at bit t.
  assign w_mask    = (IDX_W'(1) << t_q) - IDX_W'(1);
  assign w_i       = ((p_q & ~w_mask) << 1) | (p_q & w_mask);
  assign w_j       = w_i | (IDX_W'(1) << t_q);
  assign w_p_last  = (IDX_W'(1) << (n_q - MAX_QBIT_WIDTH'(1))) - IDX_W'(1);
  assign w_ctl_ok  = !cv_q || (|(w_i & (IDX_W'(1) << c_q)));
  assign w_gate_ok = (t_q < n_q) && !(cv_q && (c_q >= n_q));

  assign w_use_j    = (step_q == 3'd1) || (step_q == 3'd2) || (step_q == 3'd4);
  assign w_eng_idx  = w_use_j ? w_j : w_i;
  assign w_eng_addr = w_eng_idx[IDX_W-1:PE_NUM_WIDTH];
  assign w_eng_lane = w_eng_idx[PE_NUM_WIDTH-1:0];
  assign w_eng_din  = (step_q == 3'd3) ? w_a_new : w_b_new;

  qea_butterfly #(
    .DATA_WIDTH   (ALU_DATA_WIDTH),
    .NUM_FRAC_BIT (NUM_FRAC_BIT)
  ) u_bfly (
    .a_i   (a_q),
    .b_i   (b_q),
    .u00_i (u_q[0]),
    .u01_i (u_q[1]),
    .u10_i (u_q[2]),
    .u11_i (u_q[3]),
    .a_o   (w_a_new),
    .b_o   (w_b_new)
  );

  always_ff @(posedge clk) begin
    if (w_host && i_ctx_en && i_ctx_wea) ctx_mem[i_ctx_addr] <= i_ctx_data;
    ctx_rd_q <= ctx_mem[pc_q];
  end

  for (genvar g = 0; g < PE_NUM; g++) begin : g_lane
    logic [SDW-1:0] mem [2**STATE_ADDR_WIDTH];
    logic [SDW-1:0] eng_rd_q;
    logic [SDW-1:0] dout_q;
    logic           eng_we;

    assign eng_we = (state_q == S_APPLY) && ((step_q == 3'd3) || (step_q == 3'd4))
                    && (w_eng_lane == PE_NUM_WIDTH'(g));

    always_ff @(posedge clk) begin
      if (w_host && i_state_ena[g] && i_state_wea[g])
        mem[i_state_addra] <= i_state_dina[(PE_NUM-1-g)*SDW +: SDW];
      else if (eng_we)
        mem[w_eng_addr] <= w_eng_din;
      eng_rd_q <= mem[w_eng_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                         dout_q <= '0;
      else if (w_host && i_state_ena[g])  dout_q <= mem[i_state_addra];
    end

    assign w_eng_rd[g] = eng_rd_q;
    assign o_state_dout[(PE_NUM-1-g)*SDW +: SDW] = dout_q;
  end

  assign o_complete = complete_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      step_q     <= '0;
      pc_q       <= '0;
      ld_q       <= '0;
      n_q        <= '0;
      t_q        <= '0;
      c_q        <= '0;
      cv_q       <= 1'b0;
      complete_q <= 1'b0;
      u_q[0]     <= GATE_DATA_WIDTH'({Q_ONE, 32'h0});
      u_q[1]     <= '0;
      u_q[2]     <= '0;
      u_q[3]     <= GATE_DATA_WIDTH'({Q_ONE, 32'h0});
      p_q        <= '0;
      a_q        <= '0;
      b_q        <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      pc_q       <= pc_d;
      ld_q       <= ld_d;
      n_q        <= n_d;
      t_q        <= t_d;
      c_q        <= c_d;
      cv_q       <= cv_d;
      complete_q <= complete_d;
      u_q        <= u_d;
      p_q        <= p_d;
      a_q        <= a_d;
      b_q        <= b_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    pc_d       = pc_q;
    ld_d       = ld_q;
    n_d        = n_q;
    t_d        = t_q;
    c_d        = c_q;
    cv_d       = cv_q;
    complete_d = complete_q;
    u_d        = u_q;
    p_d        = p_q;
    a_d        = a_q;
    b_d        = b_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d    = S_FETCH;
          step_d     = '0;
          pc_d       = '0;
          n_d        = i_qbit_num;
          complete_d = 1'b0;
        end
      end
      S_FETCH: begin
        if (step_q == 3'd0) begin
          step_d = 3'd1;
        end else begin
          case (w_op)
            OP_GATE: begin
              t_d     = ctx_rd_q[HDR_T_LSB +: MAX_QBIT_WIDTH];
              c_d     = ctx_rd_q[HDR_C_LSB +: MAX_QBIT_WIDTH];
              cv_d    = ctx_rd_q[HDR_CV_BIT];
              pc_d    = pc_q + GATE_CONTEXT_ADDR_WIDTH'(1);
              ld_d    = '0;
              state_d = S_LOADU;
            end
            OP_END:  state_d = S_DONE;
            default: state_d = S_DONE;
          endcase
        end
      end
      S_LOADU: begin
        // Matrix words stream one per cycle; the word addressed at ld arrives at ld+1.
        if (ld_q != '0) u_d[ld_q[1:0] - 2'd1] = ctx_rd_q;
        if (ld_q == GATE_ADDR_WIDTH'(4)) begin
          p_d     = '0;
          step_d  = '0;
          state_d = w_gate_ok ? S_APPLY : S_FETCH;
        end else begin
          pc_d = pc_q + GATE_CONTEXT_ADDR_WIDTH'(1);
          ld_d = ld_q + GATE_ADDR_WIDTH'(1);
        end
      end
      S_APPLY: begin
        case (step_q)
          3'd0:    step_d = w_ctl_ok ? 3'd1 : 3'd5;
          3'd1: begin
            a_d    = w_eng_rd[w_i[PE_NUM_WIDTH-1:0]];
            step_d = 3'd2;
          end
          3'd2: begin
            b_d    = w_eng_rd[w_j[PE_NUM_WIDTH-1:0]];
            step_d = 3'd3;
          end
          3'd3:    step_d = 3'd4;
          default: step_d = 3'd5;
        endcase
        if (step_d == 3'd5) begin
          step_d = '0;
          if (p_q == w_p_last) state_d = S_FETCH;
          else                 p_d     = p_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        complete_d = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_qea_core.sv
`default_nettype none
// tb_qea_core: directed and random gate programs checked against a state-vector reference model.
// Rev 1.0
module tb_qea_core;

  localparam logic [63:0] ONE64  = 64'h40000000_00000000;
  localparam logic [63:0] H64    = 64'h2D413CCC_00000000;
  localparam logic [63:0] HN64   = 64'hD2BEC334_00000000;
  localparam int          BUDGET = 6000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_start = 1'b0;
  logic [5:0]   i_qbit_num = '0;
  logic         i_ctx_en = 1'b0;
  logic         i_ctx_wea = 1'b0;
  logic [15:0]  i_ctx_addr = '0;
  logic [63:0]  i_ctx_data = '0;
  logic [3:0]   i_state_ena = '0;
  logic [3:0]   i_state_wea = '0;
  logic [15:0]  i_state_addra = '0;
  logic [255:0] i_state_dina = '0;
  logic         o_complete;
  logic [255:0] o_state_dout;

  always #5 clk = ~clk;

  qea_core dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (i_start),
    .i_qbit_num    (i_qbit_num),
    .i_ctx_en      (i_ctx_en),
    .i_ctx_wea     (i_ctx_wea),
    .i_ctx_addr    (i_ctx_addr),
    .i_ctx_data    (i_ctx_data),
    .i_state_ena   (i_state_ena),
    .i_state_wea   (i_state_wea),
    .i_state_addra (i_state_addra),
    .i_state_dina  (i_state_dina),
    .o_complete    (o_complete),
    .o_state_dout  (o_state_dout)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: the full amplitude vector plus the pending gate list.
  logic [63:0] amp [256];
  int          mn;
  int          g_t [$];
  int          g_c [$];
  bit          g_cv [$];
  logic [63:0] g_u [$];
  int          last_cyc;

  function automatic logic [31:0] qm(input logic [31:0] x, input logic [31:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    p = p >>> 30;
    return p[31:0];
  endfunction

  function automatic logic [63:0] cm(input logic [63:0] u, input logic [63:0] v);
    logic [31:0] re, im;
    re = qm(u[63:32], v[63:32]) - qm(u[31:0], v[31:0]);
    im = qm(u[63:32], v[31:0]) + qm(u[31:0], v[63:32]);
    return {re, im};
  endfunction

  function automatic logic [63:0] cadd(input logic [63:0] x, input logic [63:0] y);
    return {x[63:32] + y[63:32], x[31:0] + y[31:0]};
  endfunction

  task automatic model_gate(input int t, input int c, input bit cv, input int ui);
    logic [63:0] a, b;
    int j;
    if (t >= mn || (cv && c >= mn)) return;
    for (int i = 0; i < (1 << mn); i++) begin
      if (((i >> t) & 1) != 0) continue;
      if (cv && ((i >> c) & 1) == 0) continue;
      j = i | (1 << t);
      a = amp[i];
      b = amp[j];
      amp[i] = cadd(cm(g_u[ui], a), cm(g_u[ui+1], b));
      amp[j] = cadd(cm(g_u[ui+2], a), cm(g_u[ui+3], b));
    end
  endtask

  function automatic logic [63:0] hdr(input int t, input int c, input bit cv);
    logic [63:0] h;
    h = '0;
    h[63:60] = 4'h1;
    h[5:0]   = t[5:0];
    h[13:8]  = c[5:0];
    h[16]    = cv;
    return h;
  endfunction

  task automatic ctx_wr(input int a, input logic [63:0] d);
    i_ctx_en = 1'b1; i_ctx_wea = 1'b1; i_ctx_addr = a[15:0]; i_ctx_data = d;
    @(negedge clk);
    i_ctx_en = 1'b0; i_ctx_wea = 1'b0;
  endtask

  task automatic st_wr(input int a, input logic [255:0] w);
    i_state_ena = 4'hF; i_state_wea = 4'hF; i_state_addra = a[15:0]; i_state_dina = w;
    @(negedge clk);
    i_state_ena = '0; i_state_wea = '0;
  endtask

  task automatic st_rd(input int a, output logic [255:0] w);
    i_state_ena = 4'hF; i_state_wea = '0; i_state_addra = a[15:0];
    @(negedge clk);
    w = o_state_dout;
    i_state_ena = '0;
  endtask

  task automatic set_basis(input int n, input int k);
    mn = n;
    for (int i = 0; i < 256; i++) amp[i] = '0;
    amp[k] = ONE64;
  endtask

  task automatic load_state();
    for (int a = 0; a < (1 << (mn - 2)); a++)
      st_wr(a, {amp[4*a], amp[4*a+1], amp[4*a+2], amp[4*a+3]});
  endtask

  task automatic check_state(input string tag);
    logic [255:0] w;
    for (int a = 0; a < (1 << (mn - 2)); a++) begin
      st_rd(a, w);
      for (int l = 0; l < 4; l++)
        check_eq($sformatf("%s[%0d]", tag, 4*a + l), w[(3-l)*64 +: 64], amp[4*a + l]);
    end
  endtask

  task automatic add_gate(input int t, input int c, input bit cv,
                          input logic [63:0] u00, input logic [63:0] u01,
                          input logic [63:0] u10, input logic [63:0] u11);
    g_t.push_back(t); g_c.push_back(c); g_cv.push_back(cv);
    g_u.push_back(u00); g_u.push_back(u01); g_u.push_back(u10); g_u.push_back(u11);
  endtask

  task automatic load_prog(input logic [63:0] end_word);
    int a;
    a = 0;
    foreach (g_t[k]) begin
      ctx_wr(a, hdr(g_t[k], g_c[k], g_cv[k]));
      for (int m = 0; m < 4; m++) ctx_wr(a + 1 + m, g_u[4*k + m]);
      a += 5;
    end
    ctx_wr(a, end_word);
  endtask

  task automatic run_prog(input bit busy_pulse);
    int cyc;
    i_qbit_num = mn[5:0];
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    cyc = 1;
    check_eq("cmpl_clr", 64'(o_complete), 64'd0);
    while (!o_complete && cyc < BUDGET) begin
      i_start = busy_pulse && (cyc == 20);
      @(negedge clk);
      cyc++;
    end
    i_start = 1'b0;
    check_eq("done", 64'(o_complete), 64'd1);
    last_cyc = cyc;
    foreach (g_t[k]) model_gate(g_t[k], g_c[k], g_cv[k], 4*k);
    g_t.delete(); g_c.delete(); g_cv.delete(); g_u.delete();
  endtask

  initial begin
    logic [255:0] w1, w2, rd;
    int ng, op;

    repeat (3) @(negedge clk);
    check_eq("rst_cmpl", 64'(o_complete), 64'd0);
    for (int l = 0; l < 4; l++) check_eq("rst_dout", o_state_dout[l*64 +: 64], 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Read-first host port: old data returned while the new data is written.
    w1 = {64'h11111111_22222222, 64'h33333333_44444444, 64'h55555555_66666666, 64'h77777777_88888888};
    w2 = {64'hA0A0A0A0_01010101, 64'hB1B1B1B1_02020202, 64'hC2C2C2C2_03030303, 64'hD3D3D3D3_04040404};
    st_wr(0, w1);
    i_state_ena = 4'hF; i_state_wea = 4'hF; i_state_addra = '0; i_state_dina = w2;
    @(negedge clk);
    i_state_ena = '0; i_state_wea = '0;
    for (int l = 0; l < 4; l++) check_eq("rf_old", o_state_dout[l*64 +: 64], w1[l*64 +: 64]);
    st_rd(0, rd);
    for (int l = 0; l < 4; l++) check_eq("rf_new", rd[l*64 +: 64], w2[l*64 +: 64]);
    i_state_addra = 16'd5;
    @(negedge clk);
    for (int l = 0; l < 4; l++) check_eq("rf_hold", o_state_dout[l*64 +: 64], w2[l*64 +: 64]);

    // Empty program on |0>, n=8.
    set_basis(8, 0);
    load_state();
    load_prog(64'h0);
    run_prog(1'b0);
    check_eq("end_lat_le4", 64'(last_cyc <= 4), 64'd1);
    check_state("end");

    // X on qubit 0.
    add_gate(0, 0, 1'b0, 64'h0, ONE64, ONE64, 64'h0);
    load_prog(64'h0);
    run_prog(1'b0);
    check_state("x_t0");

    // H on qubit 7 from |0>.
    set_basis(8, 0);
    load_state();
    add_gate(7, 0, 1'b0, H64, H64, H64, HN64);
    load_prog(64'h0);
    run_prog(1'b0);
    check_state("h_t7");

    // CNOT c=0, t=1: flips only where bit 0 is set.
    set_basis(8, 1);
    load_state();
    add_gate(1, 0, 1'b1, 64'h0, ONE64, ONE64, 64'h0);
    load_prog(64'h0);
    run_prog(1'b0);
    check_state("cnot_1");
    set_basis(8, 0);
    load_state();
    add_gate(1, 0, 1'b1, 64'h0, ONE64, ONE64, 64'h0);
    load_prog(64'h0);
    run_prog(1'b0);
    check_state("cnot_0");

    // Out-of-range target and control are skipped; undefined opcode ends the program.
    set_basis(4, 3);
    load_state();
    add_gate(4, 0, 1'b0, 64'h0, ONE64, ONE64, 64'h0);
    add_gate(0, 5, 1'b1, 64'h0, ONE64, ONE64, 64'h0);
    add_gate(1, 0, 1'b0, 64'h0, ONE64, ONE64, 64'h0);
    load_prog(64'h0);
    run_prog(1'b0);
    check_state("skip");
    load_prog({4'hB, 60'h0});
    ctx_wr(1, hdr(0, 0, 1'b0));
    run_prog(1'b0);
    check_state("bad_op");

    // A start pulse during execution must not restart the program.
    mn = 8;
    for (int i = 0; i < 256; i++) amp[i] = {$urandom, $urandom};
    load_state();
    add_gate(3, 0, 1'b0, 64'h0, ONE64, ONE64, 64'h0);
    load_prog(64'h0);
    run_prog(1'b1);
    check_state("busy_start");

    // Reset mid-run: outputs clear and the core runs normally afterwards.
    set_basis(8, 0);
    load_state();
    add_gate(7, 0, 1'b0, H64, H64, H64, HN64);
    load_prog(64'h0);
    st_rd(0, rd);
    check_eq("pre_rst_rd", rd[255:192], ONE64);
    i_qbit_num = 6'd8;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_cmpl", 64'(o_complete), 64'd0);
    for (int l = 0; l < 4; l++) check_eq("mid_rst_dout", o_state_dout[l*64 +: 64], 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    g_t.delete(); g_c.delete(); g_cv.delete(); g_u.delete();
    set_basis(8, 5);
    load_state();
    add_gate(2, 0, 1'b0, 64'h0, ONE64, ONE64, 64'h0);
    load_prog(64'h0);
    run_prog(1'b0);
    check_state("post_rst");

    // Random programs on random states.
    for (int trial = 0; trial < 5; trial++) begin
      mn = $urandom_range(2, 8);
      for (int i = 0; i < 256; i++) amp[i] = {$urandom, $urandom};
      load_state();
      ng = $urandom_range(1, 3);
      for (int k = 0; k < ng; k++)
        add_gate($urandom_range(0, mn), $urandom_range(0, mn - 1), 1'($urandom_range(0, 1)),
                 {$urandom, $urandom}, {$urandom, $urandom},
                 {$urandom, $urandom}, {$urandom, $urandom});
      op = $urandom_range(0, 14);
      if (op >= 1) op++;
      load_prog({op[3:0], 28'h0, $urandom});
      run_prog(1'b0);
      check_state($sformatf("rnd%0d", trial));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
